// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end:
// fetch FSM state, reset/step constants and the {pc, instr} fetch entry.
package if_pkg;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with clear; push and pop in the same cycle are
// both honoured, including when full.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, so clearing data would only cost logic.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: fetch FSM, prefetch FIFO and IF/ID register.
// Define IF_PREFETCH_BYPASS_EN to forward ack data straight to an empty output.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flush,
  input  logic               freeze,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  if_state_e          r_state;
  if_state_e          w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_hold_addr;
  logic               r_pending;
  logic               r_out_valid;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [INSTR_W-1:0] r_out_instr;

  logic               w_mem_req;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_fetch_ack;
  logic               w_load;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic [ENT_W-1:0]   w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_addr  = r_fetch_pc;
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        w_mem_req = r_pending | (w_fifo_count < CNT_W'(DEPTH));
        if (branch_taken && w_mem_req && !mem_ack) w_state_nxt = DISCARD;
      end
      DISCARD: begin
        // The abandoned access must complete at its original address.
        w_mem_req  = 1'b1;
        w_mem_addr = r_hold_addr;
        if (mem_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
    if (rst) w_mem_req = 1'b0;
  end

  assign w_next_pc   = r_fetch_pc + PC_STEP;
  assign w_fetch_ack = (r_state == FETCH) & w_mem_req & mem_ack & ~branch_taken;
  assign w_load      = ~branch_taken & ~flush & ~freeze;
  assign w_pop       = w_load & ~w_fifo_empty;

`ifdef IF_PREFETCH_BYPASS_EN
  assign w_bypass = w_load & w_fifo_empty & w_fetch_ack;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_fetch_ack & ~w_bypass & (~w_fifo_full | w_pop);

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (branch_taken),
    .i_wdata ({w_next_pc, mem_rdata}),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_fetch_pc  <= RESET_PC;
      r_hold_addr <= RESET_PC;
      r_pending   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (branch_taken)     r_fetch_pc <= branch_addr;
      else if (w_fetch_ack) r_fetch_pc <= w_next_pc;
      if (r_state == FETCH) r_hold_addr <= r_fetch_pc;
      r_pending <= (r_state == FETCH) & w_mem_req & ~mem_ack & ~branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
    end else if (branch_taken || flush) begin
      r_out_valid <= 1'b0;
    end else if (!freeze) begin
      if (!w_fifo_empty) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= w_fifo_rdata[ENT_W-1 -: ADDR_W];
        r_out_instr <= w_fifo_rdata[INSTR_W-1:0];
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= w_next_pc;
        r_out_instr <= mem_rdata;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mem_req   = w_mem_req;
  assign mem_addr  = w_mem_addr;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_instr;

endmodule
